uart_tx_scheduler: RTL and testbench
====================================

# uart_tx_scheduler

Round-robin scheduler that shares a single 8N1 UART transmit line between `NUM_REQ` byte producers. Each requester offers one byte at a time over a valid/ready handshake. A requester can keep the grant across a multi-byte message by holding `reqLast` low. The block owns the baud timing, derived from `clk`, and the serializer, and sits between the message sources and the board TX pin.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, ≥2.
- `CLOCK_RATE`, 100_000: `clk` frequency in Hz.
- `BAUD_RATE`, 9600: line rate. `CPB = CLOCK_RATE/BAUD_RATE` (integer divide, must be ≥2) is the number of clocks per bit.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rstN`  in  1  asynchronous, active-low reset.
- `reqValid`  in  NUM_REQ  requester i has a byte to send.
- `reqData`  in  8*NUM_REQ  byte for requester i is on bits [8i+7:8i].
- `reqLast`  in  NUM_REQ  1 = this byte ends requester i's message (releases the grant).
- `reqReady`  out  NUM_REQ  one-hot or zero; byte i is accepted on the edge where `reqValid[i] && reqReady[i]`.
- `tx`  out  1  serial line; idles high.
- `idle`  out  1  1 when state is IDLE and no lock is held.
- `grantId`  out  $clog2(NUM_REQ)  index of the most recently accepted requester.

## Operation
- States: IDLE, START, DATA, STOP.
- IDLE:
  - `tx`=1.
  - Select one requester combinationally and drive its `reqReady` high.
  - On handshake: capture the byte into the shift register, update `grantId`, then go to START.
- START: `tx`=0 for CPB cycles, then DATA.
- DATA: 8 bits, LSB first, each held CPB cycles; bit counter runs 0..7. Then STOP.
- STOP: `tx`=1 for CPB cycles, then IDLE.
- The bit timer resets to 0 on every state entry, so bit boundaries are exact multiples of CPB from acceptance.
- Selection, unlocked: search starts at `(grantId+1) mod NUM_REQ` and takes the first index with `reqValid` high. If none is valid, no `reqReady` is asserted.
- Selection, locked: only the lock owner (`grantId`) is eligible. Other requesters stall even if their `reqValid` is high; there is no timeout.
- Lock update on each accept of a byte from requester i:
  - `reqLast[i]`=0: lock set, owner = i.
  - `reqLast[i]`=1: lock cleared.
- `reqData` and `reqLast` are sampled only at the handshake edge; sources may change them afterwards.
- `reqValid` may drop without a handshake; no byte is sent for it.
- `reqReady` is 0 in START, DATA and STOP.

## Timing
- Reset values: `tx`=1, `idle`=1, `reqReady`=0 while `rstN`=0, `grantId`=NUM_REQ-1 (so requester 0 has first priority), lock=0, state=IDLE, counters=0.
- Reset mid-frame: `tx` goes to 1 asynchronously, the partial frame is abandoned, and the lock is cleared.
- `reqReady` is a combinational function of `reqValid`, state, lock and `grantId`; there is no combinational path from `reqData`.
- Accept at edge T: `tx` falls in cycle T+1.
- Start bit: cycles T+1 .. T+CPB.
- Data bit k: cycles T+1+(k+1)·CPB .. T+(k+2)·CPB.
- Stop bit ends at cycle T+10·CPB; IDLE is entered in cycle T+10·CPB+1.
- The earliest next accept is at the end of that IDLE cycle, giving a frame period of 10·CPB+1 cycles with a guaranteed 1-cycle extra stop.
- `idle` is registered with the state: 0 from T+1 until IDLE re-entry, and stays 0 in IDLE while the lock is held.
- Simultaneous valid from several requesters: exactly one `reqReady` is asserted, following round-robin order.

## Test plan
Configuration for all scenarios: CLOCK_RATE=8, BAUD_RATE=1 (CPB=8), NUM_REQ=4.
- Single byte: after reset, requester 0 sends 0x11 with `reqLast`=1.
  - `reqReady[0]`=1 in the same cycle.
  - `tx` pattern: 0 for 8 cycles, then bits 1,0,0,0,1,0,0,0 for 8 cycles each, then 1.
  - `idle` is 1 again 81 cycles after accept; `grantId`=0.
- Fairness: requesters 0-3 present 0xA0-0xA3 simultaneously, each with `reqLast`=1.
  - Frames go out in order A0, A1, A2, A3.
  - Accept edges are 81 cycles apart.
- Lock: requester 1 sends 0x11, 0x22, 0x44 with `reqLast` only on 0x44, while requester 2 holds 0x55 valid throughout.
  - Line order is 11, 22, 44, 55.
  - `grantId`=1 across the first three frames; `reqReady[2]`=0 until 0x44 completes.
- Lock stall: requester 1 sends 0x11 with `reqLast`=0, then drops `reqValid`, while requester 3 is valid.
  - `tx` stays 1 indefinitely, `idle`=0, and `reqReady` stays 0.
  - When requester 1 sends 0x22 with `reqLast`=1, that frame goes out, followed by requester 3's byte.
- Reset in DATA: assert `rstN`=0 at bit 3 of a frame.
  - `tx`=1 immediately; `idle`=1.
  - After release, with requesters 0 and 2 valid, requester 0 is granted first.
- Alternation: requesters 0 and 3 are both continuously valid with `reqLast`=1.
  - `grantId` alternates 0, 3, 0, 3 and neither requester is starved.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter that shares one 8N1 UART transmitter between NUM_REQ byte sources.
// A source keeps the grant across a message by presenting reqLast=0 on its bytes.
module uart_tx_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int CLOCK_RATE = 100_000,
    parameter int BAUD_RATE  = 9600
) (
    input  logic                       clk,
    input  logic                       rstN,
    input  logic [NUM_REQ-1:0]         reqValid,
    input  logic [8*NUM_REQ-1:0]       reqData,
    input  logic [NUM_REQ-1:0]         reqLast,
    output logic [NUM_REQ-1:0]         reqReady,
    output logic                       tx,
    output logic                       idle,
    output logic [$clog2(NUM_REQ)-1:0] grantId
);

    localparam int CPB = CLOCK_RATE / BAUD_RATE;
    localparam int TW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int GW  = $clog2(NUM_REQ);
    localparam logic [TW-1:0] TIMER_LAST = TW'(CPB - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            lock_q, lock_d;
    logic [GW-1:0]   grant_q, grant_d;

    logic            sel_found;
    logic [GW-1:0]   sel_idx;
    logic [GW-1:0]   cand_idx;
    int              cand;
    logic [7:0]      sel_byte;
    logic            sel_last;
    logic            accept;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = grant_q;
        cand_idx  = '0;
        cand      = 0;
        if (lock_q) begin
            sel_found = reqValid[grant_q];
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand = int'(grant_q) + k;
                if (cand >= NUM_REQ) cand = cand - NUM_REQ;
                cand_idx = GW'(cand);
                if (!sel_found && reqValid[cand_idx]) begin
                    sel_found = 1'b1;
                    sel_idx   = cand_idx;
                end
            end
        end
    end

    // Byte and last flag are muxed separately so reqReady never depends on reqData.
    always_comb begin
        sel_byte = '0;
        sel_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_idx == GW'(i)) begin
                sel_byte = reqData[8*i +: 8];
                sel_last = reqLast[i];
            end
        end
    end

    assign accept   = (state_q == S_IDLE) && sel_found;
    assign reqReady = (rstN && accept) ? (NUM_REQ'(1) << sel_idx) : '0;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        lock_d  = lock_q;
        grant_d = grant_q;
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                tx_d    = 1'b1;
                if (accept) begin
                    state_d = S_START;
                    tx_d    = 1'b0;
                    bit_d   = '0;
                    shift_d = sel_byte;
                    grant_d = sel_idx;
                    lock_d  = !sel_last;
                end
            end
            S_START: begin
                if (timer_q == TIMER_LAST) begin
                    state_d = S_DATA;
                    timer_d = '0;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                if (timer_q == TIMER_LAST) begin
                    timer_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            S_STOP: begin
                if (timer_q == TIMER_LAST) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            lock_q  <= 1'b0;
            grant_q <= GW'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            lock_q  <= lock_d;
            grant_q <= grant_d;
        end
    end

    assign tx      = tx_q;
    assign idle    = (state_q == S_IDLE) && !lock_q;
    assign grantId = grant_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with CPB=8 and four requesters.
// Inputs change and outputs are sampled just after the falling edge.
module tb_uart_tx_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx;
    logic        idle;
    logic [1:0]  grant_id;

    int checks = 0;
    int errors = 0;

    uart_tx_scheduler #(
        .NUM_REQ   (4),
        .CLOCK_RATE(8),
        .BAUD_RATE (1)
    ) dut (
        .clk     (clk),
        .rstN    (rst_n),
        .reqValid(req_valid),
        .reqData (req_data),
        .reqLast (req_last),
        .reqReady(req_ready),
        .tx      (tx),
        .idle    (idle),
        .grantId (grant_id)
    );

    always #5 clk = ~clk;

    task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
        req_valid[i]      = v;
        req_data[8*i +: 8] = d;
        req_last[i]       = l;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        rst_n     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Returns in the first cycle after the accept edge, or with ok=0 after max_cycles.
    task automatic wait_accept(input int max_cycles, output int idx, output int waited, output bit ok);
        ok     = 1'b0;
        idx    = -1;
        waited = 0;
        for (int n = 0; n < max_cycles; n++) begin
            #1;
            if (|(req_valid & req_ready)) begin
                for (int i = 0; i < 4; i++) if (req_valid[i] && req_ready[i]) idx = i;
                waited = n;
                ok     = 1'b1;
                @(posedge clk);
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
    endtask

    // Samples the 80 frame cycles; framing must be exact, b holds the decoded byte.
    task automatic rx_frame(output logic [7:0] b, output bit good);
        int slot;
        good = 1'b1;
        b    = '0;
        for (int c = 0; c < 80; c++) begin
            slot = c / 8;
            if (slot == 0) begin
                if (tx !== 1'b0) good = 1'b0;
            end else if (slot == 9) begin
                if (tx !== 1'b1) good = 1'b0;
            end else if (c % 8 == 0) begin
                b[3'(slot - 1)] = tx;
            end else if (tx !== b[3'(slot - 1)]) begin
                good = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b1;
        req_valid = 4'hF;
        req_data  = '0;
        req_last  = 4'hF;
        #2 rst_n = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (tx !== 1'b1 || idle !== 1'b1) begin
            errors++;
            $display("FAIL reset_line: tx=%b idle=%b expected tx=1 idle=1", tx, idle);
        end
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready: reqReady=%b expected 0000", req_ready);
        end
        checks++;
        if (grant_id !== 2'd3) begin
            errors++;
            $display("FAIL reset_grant: grantId=%0d expected 3", grant_id);
        end
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int idx, waited;
        bit ok, good;
        logic [7:0] b;
        set_req(0, 1'b1, 8'h11, 1'b1);
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL single_ready: reqReady=%b expected 0001", req_ready);
        end
        wait_accept(20, idx, waited, ok);
        req_valid = '0;
        checks++;
        if (!ok || idx != 0 || waited != 0) begin
            errors++;
            $display("FAIL single_accept: ok=%0d idx=%0d waited=%0d expected ok=1 idx=0 waited=0", ok, idx, waited);
        end
        checks++;
        if (idle !== 1'b0) begin
            errors++;
            $display("FAIL single_busy: idle=%b expected 0", idle);
        end
        rx_frame(b, good);
        checks++;
        if (!good || b !== 8'h11) begin
            errors++;
            $display("FAIL single_frame: byte=%h framing_ok=%0d expected byte=11 framing_ok=1", b, good);
        end
        checks++;
        if (idle !== 1'b1 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL single_end: idle=%b grantId=%0d expected idle=1 grantId=0", idle, grant_id);
        end
    endtask

    task automatic test_fairness();
        int idx, waited;
        bit ok, good;
        logic [7:0] b;
        apply_reset();
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'hA0 + 8'(i), 1'b1);
        for (int i = 0; i < 4; i++) begin
            wait_accept(200, idx, waited, ok);
            if (idx >= 0) req_valid[idx] = 1'b0;
            checks++;
            if (!ok || idx != i || waited != 0) begin
                errors++;
                $display("FAIL fair_accept_%0d: ok=%0d idx=%0d waited=%0d expected ok=1 idx=%0d waited=0", i, ok, idx, waited, i);
            end
            rx_frame(b, good);
            checks++;
            if (!good || b !== 8'hA0 + 8'(i)) begin
                errors++;
                $display("FAIL fair_frame_%0d: byte=%h framing_ok=%0d expected byte=%h framing_ok=1", i, b, good, 8'hA0 + 8'(i));
            end
        end
    endtask

    task automatic test_lock();
        int idx, waited;
        bit ok, good;
        logic [7:0] b;
        logic [7:0] msg [3] = '{8'h11, 8'h22, 8'h44};
        set_req(1, 1'b1, 8'h11, 1'b0);
        set_req(2, 1'b1, 8'h55, 1'b1);
        for (int f = 0; f < 3; f++) begin
            #1;
            checks++;
            if (req_ready !== 4'b0010) begin
                errors++;
                $display("FAIL lock_ready_%0d: reqReady=%b expected 0010", f, req_ready);
            end
            wait_accept(200, idx, waited, ok);
            if (f < 2) set_req(1, 1'b1, msg[f+1], f == 1);
            else req_valid[1] = 1'b0;
            checks++;
            if (!ok || idx != 1 || waited != 0 || grant_id !== 2'd1) begin
                errors++;
                $display("FAIL lock_accept_%0d: ok=%0d idx=%0d waited=%0d grantId=%0d expected idx=1 waited=0 grantId=1", f, ok, idx, waited, grant_id);
            end
            rx_frame(b, good);
            checks++;
            if (!good || b !== msg[f]) begin
                errors++;
                $display("FAIL lock_frame_%0d: byte=%h framing_ok=%0d expected byte=%h", f, b, good, msg[f]);
            end
            if (f < 2) begin
                checks++;
                if (idle !== 1'b0) begin
                    errors++;
                    $display("FAIL lock_idle_%0d: idle=%b expected 0", f, idle);
                end
            end
        end
        wait_accept(20, idx, waited, ok);
        req_valid[2] = 1'b0;
        checks++;
        if (!ok || idx != 2 || waited != 0) begin
            errors++;
            $display("FAIL lock_release: ok=%0d idx=%0d waited=%0d expected idx=2 waited=0", ok, idx, waited);
        end
        rx_frame(b, good);
        checks++;
        if (!good || b !== 8'h55) begin
            errors++;
            $display("FAIL lock_tail: byte=%h framing_ok=%0d expected byte=55", b, good);
        end
    endtask

    task automatic test_lock_stall();
        int idx, waited;
        bit ok, good, bad;
        logic [7:0] b;
        apply_reset();
        set_req(1, 1'b1, 8'h11, 1'b0);
        set_req(3, 1'b1, 8'hB3, 1'b1);
        wait_accept(20, idx, waited, ok);
        req_valid[1] = 1'b0;
        checks++;
        if (!ok || idx != 1) begin
            errors++;
            $display("FAIL stall_first: ok=%0d idx=%0d expected idx=1", ok, idx);
        end
        rx_frame(b, good);
        checks++;
        if (!good || b !== 8'h11) begin
            errors++;
            $display("FAIL stall_frame: byte=%h framing_ok=%0d expected byte=11", b, good);
        end
        bad = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (tx !== 1'b1 || idle !== 1'b0 || req_ready !== 4'b0000) bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL stall_hold: tx=%b idle=%b reqReady=%b expected tx=1 idle=0 reqReady=0000 throughout", tx, idle, req_ready);
        end
        set_req(1, 1'b1, 8'h22, 1'b1);
        wait_accept(20, idx, waited, ok);
        req_valid[1] = 1'b0;
        checks++;
        if (!ok || idx != 1 || waited != 0) begin
            errors++;
            $display("FAIL stall_resume: ok=%0d idx=%0d waited=%0d expected idx=1 waited=0", ok, idx, waited);
        end
        rx_frame(b, good);
        checks++;
        if (!good || b !== 8'h22) begin
            errors++;
            $display("FAIL stall_resume_frame: byte=%h expected byte=22", b);
        end
        wait_accept(20, idx, waited, ok);
        req_valid[3] = 1'b0;
        checks++;
        if (!ok || idx != 3 || waited != 0) begin
            errors++;
            $display("FAIL stall_other: ok=%0d idx=%0d waited=%0d expected idx=3 waited=0", ok, idx, waited);
        end
        rx_frame(b, good);
        checks++;
        if (!good || b !== 8'hB3) begin
            errors++;
            $display("FAIL stall_other_frame: byte=%h expected byte=b3", b);
        end
    endtask

    task automatic test_reset_mid();
        int idx, waited;
        bit ok, good;
        logic [7:0] b;
        apply_reset();
        set_req(0, 1'b1, 8'hA5, 1'b0);
        wait_accept(20, idx, waited, ok);
        req_valid[0] = 1'b0;
        repeat (34) @(negedge clk);
        checks++;
        if (!ok || tx !== 1'b0) begin
            errors++;
            $display("FAIL midreset_bit3: ok=%0d tx=%b expected tx=0", ok, tx);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || idle !== 1'b1 || grant_id !== 2'd3) begin
            errors++;
            $display("FAIL midreset_async: tx=%b idle=%b grantId=%0d expected tx=1 idle=1 grantId=3", tx, idle, grant_id);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_req(0, 1'b1, 8'h3C, 1'b1);
        set_req(2, 1'b1, 8'h7E, 1'b1);
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL midreset_ready: reqReady=%b expected 0001", req_ready);
        end
        wait_accept(20, idx, waited, ok);
        req_valid[0] = 1'b0;
        rx_frame(b, good);
        checks++;
        if (!ok || idx != 0 || !good || b !== 8'h3C) begin
            errors++;
            $display("FAIL midreset_first: idx=%0d byte=%h expected idx=0 byte=3c", idx, b);
        end
        wait_accept(20, idx, waited, ok);
        req_valid[2] = 1'b0;
        rx_frame(b, good);
        checks++;
        if (!ok || idx != 2 || waited != 0 || !good || b !== 8'h7E) begin
            errors++;
            $display("FAIL midreset_second: idx=%0d waited=%0d byte=%h expected idx=2 waited=0 byte=7e", idx, waited, b);
        end
    endtask

    task automatic test_alternation();
        int idx, waited;
        bit ok, good;
        logic [7:0] b;
        int exp_idx;
        apply_reset();
        set_req(0, 1'b1, 8'hC0, 1'b1);
        set_req(3, 1'b1, 8'hC3, 1'b1);
        for (int i = 0; i < 4; i++) begin
            exp_idx = (i % 2 == 0) ? 0 : 3;
            wait_accept(200, idx, waited, ok);
            checks++;
            if (!ok || idx != exp_idx || waited != 0 || grant_id !== 2'(exp_idx)) begin
                errors++;
                $display("FAIL alt_accept_%0d: idx=%0d waited=%0d grantId=%0d expected idx=%0d waited=0", i, idx, waited, grant_id, exp_idx);
            end
            rx_frame(b, good);
            checks++;
            if (!good || b !== ((exp_idx == 0) ? 8'hC0 : 8'hC3)) begin
                errors++;
                $display("FAIL alt_frame_%0d: byte=%h framing_ok=%0d expected idx %0d byte", i, b, good, exp_idx);
            end
        end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_lock();
        test_lock_stall();
        test_reset_mid();
        test_alternation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
